prof_event_tracer: RTL and testbench
====================================

// Module: prof_event_tracer
// PURPOSE
//  Synthesizable per-CU producer of execution-profiling events. Samples issue (select) and completion
//  strobes of SALU, 4x SIMD, 4x SIMF and LSU each cycle, timestamps them, buffers them and transmits
//  64-bit trace records over a valid/ready stream to an off-CU trace reader/host. Hardware-side source
//  of the same start/finish event stream the simulation profiler consumes.
// PARAMETERS
//  CUID        0   compute-unit id placed in every record (0..255)
//  FIFO_DEPTH  16  record buffer entries; power of two, >=2
//  TS_WIDTH    32  timestamp counter width (1..32), zero-extended into the record
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous reset, active low
//  prof_en        in   1   1 = capture events; 0 = capture nothing (timestamp still runs)
//  salu_start     in   1   SALU instruction selected
//  salu_finish    in   1   SALU instr_done or branch_en
//  mem_start      in   1   LSU instruction selected
//  mem_finish     in   1   LSU sgpr or vgpr instr_done
//  valu_start     in   8   [3:0] simd0-3 select, [7:4] simf0-3 select
//  valu_finish    in   8   [3:0] simd0-3 writeback done, [7:4] simf0-3 writeback done
//  out_valid      out  1   trace record available
//  out_ready      in   1   reader accepts record
//  out_data       out  64  record: [63:56] CUID, [55] wrap, [54:52] drops, [51:32] events, [31:0] ts
//  fifo_level     out  $clog2(FIFO_DEPTH)+1  buffered record count
//  overflow       out  1   sticky: at least one record dropped since reset
// BEHAVIOUR
//  - Reset: ts=0, FIFO empty, out_valid=0, out_data=0, fifo_level=0, overflow=0, drop count=0, wrap pulse=0.
//  - ts: increments every cycle regardless of prof_en/backpressure; wraps 2^TS_WIDTH-1 -> 0.
//  - wrap pulse: register set in the cycle after ts==max (i.e. high exactly in ts==0 cycles after a wrap).
//  - Event vector ev[19:0] = {valu_finish, valu_start, mem_finish, mem_start, salu_finish, salu_start}.
//  - Capture: when prof_en && (ev!=0 || wrap pulse), exactly one record is formed that cycle with
//    the current ts (all simultaneous events share one record; wrap-only record has ev=0, wrap=1).
//  - Push accepted if !full, or full && out_valid && out_ready (simultaneous pop frees slot) -> no drop.
//  - Otherwise the record is dropped: drops counter +1 saturating at 7; overflow set, held until reset.
//  - Drops field of the next accepted record = counter value before that cycle; counter clears on that
//    push (a drop in the same cycle cannot occur since the push was accepted).
//  - Output: out_valid = !empty; out_data = head entry (0 when empty). Record captured at edge N is
//    visible on out_valid/out_data after edge N (one-cycle latency when empty); no combinational
//    ready->valid path. out_data stable while out_valid && !out_ready. Pop on out_valid && out_ready.
//  - Push and pop same cycle: level unchanged; FIFO order strictly preserved; pointers wrap modulo depth.
//  - fifo_level = pushes - pops, 0..FIFO_DEPTH, updated at edge.
//  - rst_n asserted mid-stream: all buffered records discarded, outputs to reset values immediately
//    (asynchronous); reader must tolerate truncated stream.
// STRUCTURE
//  - Package prof_trace_pkg: record width (64), field bit positions, event-bit indices, drops max (7).
//  - Sub-module prof_trace_fifo: sync FIFO (DEPTH, WIDTH=64) with full/empty/level, async active-low
//    reset, head-visible read. Top holds ts counter, wrap pulse, event packing, drop/overflow logic.
// TESTING
//  1. Reset, prof_en=1, salu_start pulse when ts=5 -> next cycle out_valid=1,
//     out_data={CUID,1'b0,3'd0,20'h00001,32'd5}; after out_ready, out_valid=0, fifo_level=0.
//  2. valu_finish[3] and mem_finish in same cycle at ts=9 -> single record, events=20'h08008, ts=9.
//  3. out_ready=0, events on 20 consecutive cycles, depth 16 -> fifo_level=16, overflow=1; drain with
//     out_ready=1; next new event record has drops=4, overflow stays 1.
//  4. TS_WIDTH=4, prof_en=1, no events -> record every 16 cycles with wrap=1, events=0, ts=0;
//     none at ts=0 directly after reset; with prof_en=0 no records at all.
//  5. FIFO full, out_ready=1 and new event same cycle -> no drop, fifo_level stays 16, order preserved.
//  6. rst_n low mid-stream with 10 records buffered -> out_valid=0, fifo_level=0, overflow=0 at once;
//     after release ts restarts at 0 and first new record is correct.

Source files
------------

// File: rtl/prof_trace_pkg.sv
// Shared record layout, event-bit indices and drop-counter limits for the
// per-CU profiling event tracer.
package prof_trace_pkg;

    localparam int REC_W      = 64;
    localparam int EV_W       = 20;
    localparam int DROPS_W    = 3;
    localparam int VALU_LANES = 8;

    localparam int CUID_LSB   = 56;
    localparam int WRAP_BIT   = 55;
    localparam int DROPS_LSB  = 52;
    localparam int EV_LSB     = 32;
    localparam int TS_LSB     = 0;

    localparam int EV_SALU_START   = 0;
    localparam int EV_SALU_FINISH  = 1;
    localparam int EV_MEM_START    = 2;
    localparam int EV_MEM_FINISH   = 3;
    localparam int EV_VALU_START   = 4;
    localparam int EV_VALU_FINISH  = 12;

    localparam logic [DROPS_W-1:0] DROPS_MAX = 3'd7;

    // Field order matches the bit positions above: cuid in the top byte, ts in the low word.
    typedef struct packed {
        logic [7:0]         cuid;
        logic               wrap;
        logic [DROPS_W-1:0] drops;
        logic [EV_W-1:0]    events;
        logic [31:0]        ts;
    } trace_rec_t;

    typedef enum logic [1:0] {
        CAP_NONE,
        CAP_PUSH,
        CAP_DROP
    } cap_action_t;

    function automatic logic [DROPS_W-1:0] drops_sat_inc(input logic [DROPS_W-1:0] d);
        return (d == DROPS_MAX) ? d : d + DROPS_W'(1);
    endfunction

endpackage

// File: rtl/prof_event_tracer_if.sv
// Valid/ready trace-record stream from the tracer (master) to the trace reader (slave).
interface prof_event_tracer_if;
    import prof_trace_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [REC_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/prof_trace_fifo.sv
// Synchronous record FIFO with head-visible read, level count and
// asynchronous active-low reset of the pointers.
module prof_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0] level_reg, level_next;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    // Storage carries no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Head read is combinational so a record is visible the cycle after capture.
    assign head_data = mem[rd_ptr_reg];

endmodule

// File: rtl/prof_event_tracer.sv
// Per-CU profiling event tracer: timestamps SALU/VALU/LSU issue and completion
// strobes, buffers one record per active cycle and streams them out.
module prof_event_tracer
    import prof_trace_pkg::*;
#(
    parameter int CUID       = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          prof_en,
    input  logic                          salu_start,
    input  logic                          salu_finish,
    input  logic                          mem_start,
    input  logic                          mem_finish,
    input  logic [VALU_LANES-1:0]         valu_start,
    input  logic [VALU_LANES-1:0]         valu_finish,
    prof_event_tracer_if.master           out_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam logic [TS_WIDTH-1:0] TS_MAX = {TS_WIDTH{1'b1}};

    logic [TS_WIDTH-1:0] ts_reg;
    logic                wrap_reg;
    logic [DROPS_W-1:0]  drops_reg, drops_next;
    logic                overflow_reg, overflow_next;

    logic [EV_W-1:0]     ev;
    logic                capture;
    logic                pop;
    logic                push;
    cap_action_t         cap_action;
    trace_rec_t          rec;

    logic [REC_W-1:0]    fifo_head;
    logic                fifo_full;
    logic                fifo_empty;

    assign ev[EV_SALU_START]  = salu_start;
    assign ev[EV_SALU_FINISH] = salu_finish;
    assign ev[EV_MEM_START]   = mem_start;
    assign ev[EV_MEM_FINISH]  = mem_finish;

    genvar gi;
    generate
        for (gi = 0; gi < VALU_LANES; gi++) begin : g_valu_ev
            assign ev[EV_VALU_START + gi]  = valu_start[gi];
            assign ev[EV_VALU_FINISH + gi] = valu_finish[gi];
        end
    endgenerate

    // A wrap pulse alone produces a record so the reader can extend the timestamp.
    assign capture = prof_en && ((ev != '0) || wrap_reg);
    assign pop     = !fifo_empty && out_if.out_ready;
    assign push    = (cap_action == CAP_PUSH);

    always_comb begin
        cap_action    = CAP_NONE;
        drops_next    = drops_reg;
        overflow_next = overflow_reg;
        if (capture) begin
            if (!fifo_full || pop) begin
                cap_action = CAP_PUSH;
                drops_next = '0;
            end else begin
                cap_action    = CAP_DROP;
                drops_next    = drops_sat_inc(drops_reg);
                overflow_next = 1'b1;
            end
        end
    end

    always_comb begin
        rec        = '0;
        rec.cuid   = 8'(CUID);
        rec.wrap   = wrap_reg;
        rec.drops  = drops_reg;
        rec.events = ev;
        rec.ts     = 32'(ts_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_reg       <= '0;
            wrap_reg     <= 1'b0;
            drops_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            ts_reg       <= ts_reg + TS_WIDTH'(1);
            wrap_reg     <= (ts_reg == TS_MAX);
            drops_reg    <= drops_next;
            overflow_reg <= overflow_next;
        end
    end

    prof_trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (rec),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = fifo_empty ? '0 : fifo_head;
    assign overflow         = overflow_reg;

endmodule

// File: tb/tb_prof_event_tracer.sv
// Self-checking bench for prof_event_tracer: directed scenarios plus a randomized
// run checked against a queue-based record model.
module tb_prof_event_tracer;

    localparam int         DEPTH = 16;
    localparam logic [7:0] CUID1 = 8'hA5;
    localparam logic [7:0] CUID2 = 8'h3C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 32-bit timestamp
    logic       rst_n, prof_en, salu_start, salu_finish, mem_start, mem_finish;
    logic [7:0] valu_start, valu_finish;
    logic [4:0] fifo_level;
    logic       overflow;
    prof_event_tracer_if bus1();

    // Wrap instance: 4-bit timestamp
    logic       rst2_n, prof_en2, e2_salu_start, e2_salu_finish, e2_mem_start, e2_mem_finish;
    logic [7:0] e2_valu_start, e2_valu_finish;
    logic [4:0] fifo_level2;
    logic       overflow2;
    prof_event_tracer_if bus2();

    prof_event_tracer #(.CUID(CUID1), .FIFO_DEPTH(DEPTH), .TS_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .prof_en(prof_en),
        .salu_start(salu_start), .salu_finish(salu_finish),
        .mem_start(mem_start), .mem_finish(mem_finish),
        .valu_start(valu_start), .valu_finish(valu_finish),
        .out_if(bus1), .fifo_level(fifo_level), .overflow(overflow)
    );

    prof_event_tracer #(.CUID(CUID2), .FIFO_DEPTH(DEPTH), .TS_WIDTH(4)) dut_w (
        .clk(clk), .rst_n(rst2_n), .prof_en(prof_en2),
        .salu_start(e2_salu_start), .salu_finish(e2_salu_finish),
        .mem_start(e2_mem_start), .mem_finish(e2_mem_finish),
        .valu_start(e2_valu_start), .valu_finish(e2_valu_finish),
        .out_if(bus2), .fifo_level(fifo_level2), .overflow(overflow2)
    );

    int errors = 0;
    int checks = 0;

    // Reference model of the main instance
    logic [63:0] q[$];
    logic [31:0] ts_m;
    logic        wrap_m;
    logic [2:0]  drops_m;
    logic        ovf_m;

    function automatic void model_reset();
        q.delete();
        ts_m    = 32'd0;
        wrap_m  = 1'b0;
        drops_m = 3'd0;
        ovf_m   = 1'b0;
    endfunction

    task automatic cycle();
        logic [19:0] ev;
        logic        take;
        logic        cap;
        ev   = {valu_finish, valu_start, mem_finish, mem_start, salu_finish, salu_start};
        take = (q.size() != 0) && bus1.out_ready;
        cap  = prof_en && ((ev != 20'd0) || wrap_m);
        if (bus1.out_valid && bus1.out_ready)
            $display("xfer t=%0t cuid=%h wrap=%b drops=%0d ev=%h ts=%0d", $time,
                     bus1.out_data[63:56], bus1.out_data[55], bus1.out_data[54:52],
                     bus1.out_data[51:32], bus1.out_data[31:0]);
        @(posedge clk);
        if (take) void'(q.pop_front());
        if (cap) begin
            if (q.size() < DEPTH) begin
                q.push_back({CUID1, wrap_m, drops_m, ev, ts_m});
                drops_m = 3'd0;
            end else begin
                if (drops_m != 3'd7) drops_m = drops_m + 3'd1;
                ovf_m = 1'b1;
            end
        end
        wrap_m = (ts_m == 32'hFFFF_FFFF);
        ts_m   = ts_m + 32'd1;
        #1;
    endtask

    task automatic clear_inputs();
        prof_en = 1'b1; salu_start = 0; salu_finish = 0; mem_start = 0; mem_finish = 0;
        valu_start = 8'h00; valu_finish = 8'h00; bus1.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        salu_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus1.out_valid); end
        checks++; if (bus1.out_data !== 64'd0) begin errors++; $display("FAIL rst_data got=%h exp=0", bus1.out_data); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        model_reset();
        rst_n = 1'b1;
        cycle();
        salu_start = 1'b0;
        checks++; if (bus1.out_data !== {CUID1, 1'b0, 3'd0, 20'h00001, 32'd0})
            begin errors++; $display("FAIL rst_first_rec got=%h exp=%h", bus1.out_data, {CUID1, 1'b0, 3'd0, 20'h00001, 32'd0}); end
    endtask

    task automatic test_single_event();
        do_reset();
        repeat (5) cycle();
        salu_start = 1'b1;
        cycle();
        salu_start = 1'b0;
        checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got=%b exp=1", bus1.out_valid); end
        checks++; if (bus1.out_data !== {CUID1, 1'b0, 3'd0, 20'h00001, 32'd5})
            begin errors++; $display("FAIL t1_data got=%h exp=%h", bus1.out_data, {CUID1, 1'b0, 3'd0, 20'h00001, 32'd5}); end
        bus1.out_ready = 1'b1;
        cycle();
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_after got=%b exp=0", bus1.out_valid); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL t1_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_merged_events();
        do_reset();
        repeat (9) cycle();
        valu_finish = 8'h08;
        mem_finish  = 1'b1;
        cycle();
        valu_finish = 8'h00;
        mem_finish  = 1'b0;
        checks++; if (bus1.out_data !== {CUID1, 1'b0, 3'd0, 20'h08008, 32'd9})
            begin errors++; $display("FAIL t2_data got=%h exp=%h", bus1.out_data, {CUID1, 1'b0, 3'd0, 20'h08008, 32'd9}); end
        checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL t2_level got=%0d exp=1", fifo_level); end
    endtask

    task automatic test_overflow();
        do_reset();
        salu_start = 1'b1;
        repeat (20) cycle();
        salu_start = 1'b0;
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL t3_level got=%0d exp=16", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_ovf got=%b exp=1", overflow); end
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (bus1.out_data !== {CUID1, 1'b0, 3'd0, 20'h00001, 32'(i)})
                begin errors++; $display("FAIL t3_drain%0d got=%h exp=%h", i, bus1.out_data, {CUID1, 1'b0, 3'd0, 20'h00001, 32'(i)}); end
            cycle();
        end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL t3_drained got=%0d exp=0", fifo_level); end
        bus1.out_ready = 1'b0;
        salu_start = 1'b1;
        cycle();
        salu_start = 1'b0;
        checks++; if (bus1.out_data !== {CUID1, 1'b0, 3'd4, 20'h00001, 32'd36})
            begin errors++; $display("FAIL t3_drops got=%h exp=%h", bus1.out_data, {CUID1, 1'b0, 3'd4, 20'h00001, 32'd36}); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_ovf_held got=%b exp=1", overflow); end
    endtask

    task automatic test_wrap();
        logic exp_v;
        rst2_n = 1'b0; prof_en2 = 1'b1; bus2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            exp_v = (k >= 17) && (((k - 1) % 16) == 0);
            checks++; if (bus2.out_valid !== exp_v) begin errors++; $display("FAIL t4_valid k=%0d got=%b exp=%b", k, bus2.out_valid, exp_v); end
            if (exp_v) begin
                $display("xfer t=%0t wrap record data=%h", $time, bus2.out_data);
                checks++; if (bus2.out_data !== {CUID2, 1'b1, 3'd0, 20'h00000, 32'd0})
                    begin errors++; $display("FAIL t4_data k=%0d got=%h exp=%h", k, bus2.out_data, {CUID2, 1'b1, 3'd0, 20'h00000, 32'd0}); end
            end
        end
        prof_en2 = 1'b0;
        for (int k = 0; k < 48; k++) begin
            @(posedge clk);
            #1;
            checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL t4_off k=%0d got=%b exp=0", k, bus2.out_valid); end
        end
        checks++; if (overflow2 !== 1'b0) begin errors++; $display("FAIL t4_ovf got=%b exp=0", overflow2); end
    endtask

    task automatic test_full_simultaneous();
        do_reset();
        salu_start = 1'b1;
        repeat (16) cycle();
        salu_start = 1'b0;
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL t5_full got=%0d exp=16", fifo_level); end
        mem_start = 1'b1;
        bus1.out_ready = 1'b1;
        cycle();
        mem_start = 1'b0;
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL t5_level got=%0d exp=16", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t5_ovf got=%b exp=0", overflow); end
        for (int i = 0; i < 16; i++) begin
            logic [63:0] exp_d;
            exp_d = (i < 15) ? {CUID1, 1'b0, 3'd0, 20'h00001, 32'(i + 1)}
                             : {CUID1, 1'b0, 3'd0, 20'h00004, 32'd16};
            checks++; if (bus1.out_data !== exp_d) begin errors++; $display("FAIL t5_order%0d got=%h exp=%h", i, bus1.out_data, exp_d); end
            cycle();
        end
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL t5_empty got=%b exp=0", bus1.out_valid); end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        salu_finish = 1'b1;
        repeat (10) cycle();
        salu_finish = 1'b0;
        checks++; if (fifo_level !== 5'd10) begin errors++; $display("FAIL t6_level_pre got=%0d exp=10", fifo_level); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL t6_valid got=%b exp=0", bus1.out_valid); end
        checks++; if (bus1.out_data !== 64'd0) begin errors++; $display("FAIL t6_data got=%h exp=0", bus1.out_data); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL t6_level got=%0d exp=0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t6_ovf got=%b exp=0", overflow); end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        repeat (3) cycle();
        valu_start = 8'h80;
        cycle();
        valu_start = 8'h00;
        checks++; if (bus1.out_data !== {CUID1, 1'b0, 3'd0, 20'h00800, 32'd3})
            begin errors++; $display("FAIL t6_newrec got=%h exp=%h", bus1.out_data, {CUID1, 1'b0, 3'd0, 20'h00800, 32'd3}); end
    endtask

    task automatic test_random();
        logic [63:0] exp_d;
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 200; n++) begin
                prof_en = ($urandom_range(0, 9) != 0);
                if (ph == 2) begin
                    salu_start     = 1'b1;
                    bus1.out_ready = 1'b1;
                end else begin
                    salu_start     = ($urandom_range(0, 3) == 0);
                    bus1.out_ready = (ph == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
                end
                salu_finish = ($urandom_range(0, 5) == 0);
                mem_start   = ($urandom_range(0, 5) == 0);
                mem_finish  = ($urandom_range(0, 5) == 0);
                valu_start  = 8'($urandom & $urandom & $urandom);
                valu_finish = 8'($urandom & $urandom & $urandom);
                cycle();
                exp_d = (q.size() != 0) ? q[0] : 64'd0;
                checks++; if (bus1.out_valid !== (q.size() != 0))
                    begin errors++; if (errors < 30) $display("FAIL rnd_valid ph=%0d n=%0d got=%b exp=%b", ph, n, bus1.out_valid, (q.size() != 0)); end
                checks++; if (bus1.out_data !== exp_d)
                    begin errors++; if (errors < 30) $display("FAIL rnd_data ph=%0d n=%0d got=%h exp=%h", ph, n, bus1.out_data, exp_d); end
                checks++; if (fifo_level !== 5'(q.size()))
                    begin errors++; if (errors < 30) $display("FAIL rnd_level ph=%0d n=%0d got=%0d exp=%0d", ph, n, fifo_level, q.size()); end
                checks++; if (overflow !== ovf_m)
                    begin errors++; if (errors < 30) $display("FAIL rnd_ovf ph=%0d n=%0d got=%b exp=%b", ph, n, overflow, ovf_m); end
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst2_n = 1'b0; prof_en2 = 1'b0; bus2.out_ready = 1'b0;
        e2_salu_start = 0; e2_salu_finish = 0; e2_mem_start = 0; e2_mem_finish = 0;
        e2_valu_start = 8'h00; e2_valu_finish = 8'h00;
        model_reset();
        test_reset();
        test_single_event();
        test_merged_events();
        test_overflow();
        test_wrap();
        test_full_simultaneous();
        test_midstream_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
